// File: rtl/deskew_unit.sv
// -----------------------------------------------------------------------------
// deskew_unit
//
// Realigns a staggered wavefront leaving a LANES-wide systolic array. Lane i of
// a wavefront arrives i cycles after lane 0; each lane is delayed by
// LANES-1-i register stages so that all lanes meet in the same cycle, and are
// then captured together by one common output register. A word is therefore
// visible on dout LANES cycles after its lane 0 element was presented.
//
// A partial wavefront after deskew (some but not all delayed valids set) is
// never emitted and raises the sticky align_err flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-lane valid, bit i qualifies lane i
//   din        lane data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   clr_err    synchronous clear of align_err (a new error in the same cycle wins)
//   out_valid  aligned word present on dout this cycle
//   dout       last aligned word, same lane packing as din
//   out_count  number of aligned words emitted, saturating
//   align_err  sticky misaligned-wavefront flag
// -----------------------------------------------------------------------------
module deskew_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [LANES-1:0]            in_valid,
   input  logic [LANES*DATA_WIDTH-1:0] din,
   input  logic                        clr_err,
   output logic                        out_valid,
   output logic [LANES*DATA_WIDTH-1:0] dout,
   output logic [CNT_WIDTH-1:0]        out_count,
   output logic                        align_err
);

   // Lane outputs after their individual delay lines.
   logic [LANES-1:0]            dly_valid_s;
   logic [LANES*DATA_WIDTH-1:0] dly_word_s;
   logic                        aligned_valid_s;
   logic                        any_valid_s;

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         localparam int DEPTH = LANES - 1 - g;

         if (DEPTH == 0) begin : g_wire
            // The last lane arrives latest and needs no delay.
            assign dly_word_s[g*DATA_WIDTH +: DATA_WIDTH] = din[g*DATA_WIDTH +: DATA_WIDTH];
            assign dly_valid_s[g]                        = in_valid[g];
         end else begin : g_pipe
            logic [DATA_WIDTH-1:0] data_r [DEPTH];
            logic [DEPTH-1:0]      valid_r;

            // Free-running shift line for this lane's data and valid.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  for (int k = 0; k < DEPTH; k++) begin
                     data_r[k] <= {DATA_WIDTH{1'b0}};
                  end
                  valid_r <= {DEPTH{1'b0}};
               end else begin
                  data_r[0]  <= din[g*DATA_WIDTH +: DATA_WIDTH];
                  valid_r[0] <= in_valid[g];
                  for (int k = 1; k < DEPTH; k++) begin
                     data_r[k]  <= data_r[k-1];
                     valid_r[k] <= valid_r[k-1];
                  end
               end
            end

            assign dly_word_s[g*DATA_WIDTH +: DATA_WIDTH] = data_r[DEPTH-1];
            assign dly_valid_s[g]                        = valid_r[DEPTH-1];
         end
      end
   endgenerate

   // Wavefront completeness after deskew.
   always_comb begin
      aligned_valid_s = &dly_valid_s;
      any_valid_s     = |dly_valid_s;
   end

   // Output valid follows the aligned valid every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= aligned_valid_s;
      end
   end

   // Output word loads only on a complete wavefront, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= {(LANES*DATA_WIDTH){1'b0}};
      end else if (aligned_valid_s) begin
         dout <= dly_word_s;
      end else begin
         dout <= dout;
      end
   end

   // Saturating count of emitted words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_count <= {CNT_WIDTH{1'b0}};
      end else if (aligned_valid_s && (out_count != {CNT_WIDTH{1'b1}})) begin
         out_count <= out_count + CNT_WIDTH'(1'b1);
      end else begin
         out_count <= out_count;
      end
   end

   // Sticky misalignment flag; a new error takes priority over clr_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         align_err <= 1'b0;
      end else if (any_valid_s && !aligned_valid_s) begin
         align_err <= 1'b1;
      end else if (clr_err) begin
         align_err <= 1'b0;
      end else begin
         align_err <= align_err;
      end
   end

endmodule

// File: tb/tb_deskew_unit.sv
// -----------------------------------------------------------------------------
// tb_deskew_unit
//
// Directed bench for deskew_unit with LANES=4, DATA_WIDTH=8, CNT_WIDTH=4.
// Wavefronts are scheduled by their lane 0 cycle; the expected word is pushed
// to a scoreboard tagged with the cycle it must appear on dout (start+LANES),
// and popped when that cycle is observed. Outputs are sampled on the falling
// edge, inputs are driven right after sampling.
// -----------------------------------------------------------------------------
module tb_deskew_unit;

   localparam int DW = 8;
   localparam int LN = 4;
   localparam int CW = 4;
   localparam int WW = DW * LN;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [LN-1:0] in_valid;
   logic [WW-1:0] din;
   logic          clr_err;
   logic          out_valid;
   logic [WW-1:0] dout;
   logic [CW-1:0] out_count;
   logic          align_err;

   deskew_unit #(
      .DATA_WIDTH (DW),
      .LANES      (LN),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din       (din),
      .clr_err   (clr_err),
      .out_valid (out_valid),
      .dout      (dout),
      .out_count (out_count),
      .align_err (align_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [WW-1:0] word;
   } item_t;

   item_t wf_q[$];   // scheduled wavefronts (lane 0 cycle, word)
   item_t sb_q[$];   // expected output words (output cycle, word)
   int    mis_q[$];  // cycles where all lanes are driven at once
   int    clr_q[$];  // cycles where clr_err is pulsed

   int            tests = 0;
   int            fails = 0;
   logic [WW-1:0] last_dout;
   logic [CW-1:0] exp_count;
   logic          exp_err;
   logic          cur_partial;
   logic          cur_clr;

   function automatic logic [WW-1:0] stream_word(input int k);
      logic [WW-1:0] w;
      w = {WW{1'b0}};
      for (int i = 0; i < LN; i++) begin
         w[i*DW +: DW] = DW'(k * LN + i);
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic add_wf(input int start, input logic [WW-1:0] w);
      wf_q.push_back('{start, w});
      sb_q.push_back('{start + LN, w});
   endtask

   task automatic reset_model();
      wf_q.delete();
      sb_q.delete();
      last_dout   = {WW{1'b0}};
      exp_count   = {CW{1'b0}};
      exp_err     = 1'b0;
      cur_partial = 1'b0;
      cur_clr     = 1'b0;
   endtask

   // Compare all outputs against the model for the current cycle.
   task automatic check_outputs();
      logic exp_valid;
      // Error flag is registered: it reflects the previous cycle's conditions.
      if (cur_partial) exp_err = 1'b1;
      else if (cur_clr) exp_err = 1'b0;
      exp_valid = 1'b0;
      if (sb_q.size() > 0) exp_valid = (sb_q[0].cyc == cyc);
      chk("out_valid", WW'(out_valid), WW'(exp_valid));
      if (exp_valid) begin
         last_dout = sb_q[0].word;
         void'(sb_q.pop_front());
         if (exp_count != {CW{1'b1}}) exp_count = exp_count + CW'(1);
      end
      chk("dout", dout, last_dout);
      chk("out_count", WW'(out_count), WW'(exp_count));
      chk("align_err", WW'(align_err), WW'(exp_err));
   endtask

   // Drive inputs for the current cycle from the schedules.
   task automatic drive();
      in_valid = {LN{1'b0}};
      din      = $urandom;
      while (wf_q.size() > 0 && (wf_q[0].cyc + LN - 1) < cyc) void'(wf_q.pop_front());
      foreach (wf_q[j]) begin
         for (int i = 0; i < LN; i++) begin
            if (wf_q[j].cyc + i == cyc) begin
               in_valid[i]   = 1'b1;
               din[i*DW +: DW] = wf_q[j].word[i*DW +: DW];
            end
         end
      end
      cur_partial = 1'b0;
      foreach (mis_q[j]) begin
         if (mis_q[j] == cyc) in_valid = {LN{1'b1}};
         // An un-staggered burst leaves a partial wavefront for LANES cycles.
         if (mis_q[j] <= cyc && cyc <= mis_q[j] + LN - 1) cur_partial = 1'b1;
      end
      cur_clr = 1'b0;
      foreach (clr_q[j]) begin
         if (clr_q[j] == cyc) cur_clr = 1'b1;
      end
      clr_err = cur_clr;
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      drive();
   endtask

   task automatic run_until(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = {LN{1'b1}};
      din      = $urandom;
      clr_err  = 1'b0;
      reset_model();

      // Single wavefront, then 8 back-to-back, then misalignment tests.
      add_wf(10, 32'h1312_1110);
      for (int k = 0; k < 8; k++) add_wf(20 + k, stream_word(k));
      add_wf(60, 32'hA3A2_A1A0);
      mis_q.push_back(40);
      mis_q.push_back(70);
      clr_q.push_back(50);
      clr_q.push_back(72);
      clr_q.push_back(76);

      // Reset held with all valids high and random data.
      repeat (3) begin
         @(negedge clk);
         check_outputs();
         din = $urandom;
      end
      rst_n    = 1'b1;
      in_valid = {LN{1'b0}};

      run_until(18);
      chk("single_hold_dout", dout, 32'h1312_1110);
      chk("single_count", WW'(out_count), 32'd1);

      run_until(33);
      chk("stream_count", WW'(out_count), 32'd9);  // 1 single + 8 streamed

      run_until(44);
      chk("mis_err_by_44", WW'(align_err), 32'd1);
      run_until(51);
      chk("mis_err_cleared", WW'(align_err), 32'd0);

      // Reset pulse mid-flight: lanes 0 and 1 of the cycle-60 wavefront are in
      // the delay lines; lanes 2 and 3 are never driven afterwards.
      run_until(62);
      in_valid = {LN{1'b0}};
      rst_n    = 1'b0;
      reset_model();
      #2;
      chk("rst_pulse_count", WW'(out_count), 32'd0);
      chk("rst_pulse_dout", dout, 32'd0);
      rst_n = 1'b1;

      run_until(69);
      chk("midflight_dout", dout, 32'd0);
      chk("midflight_count", WW'(out_count), 32'd0);
      chk("midflight_err", WW'(align_err), 32'd0);

      run_until(73);
      chk("set_wins_over_clr", WW'(align_err), 32'd1);

      // Saturation: 20 words into a 4-bit counter.
      for (int k = 0; k < 20; k++) add_wf(80 + k, $urandom);
      run_until(112);
      chk("sat_count", WW'(out_count), 32'd15);
      chk("sb_drained", WW'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
